// File: rtl/pulse_div_pkg.sv
// Shared constants and the divisor helper for the pulse_divider tick generator.
package pulse_div_pkg;

  localparam int unsigned MIN_DIV     = 32'd2;
  localparam int unsigned DEF_CNT_W   = 32'd26;
  localparam int unsigned DEF_DIV_VAL = 32'd50000000;
  localparam int unsigned DEF_TC_W    = 32'd16;

  // Divisor for a wanted tick rate; clamped so a bad request still yields a legal divisor.
  function automatic logic [63:0] calc_div(input logic [63:0] clk_hz, input logic [63:0] tick_hz);
    logic [63:0] q;
    if (tick_hz == 64'd0) begin
      q = 64'(MIN_DIV);
    end else begin
      q = clk_hz / tick_hz;
    end
    if (q < 64'(MIN_DIV)) begin
      q = 64'(MIN_DIV);
    end else begin
      q = q;
    end
    return q;
  endfunction

endpackage

// File: rtl/pulse_div_core.sv
// Phase counter with wrap detection and the registered single-cycle tick.
module pulse_div_core
  import pulse_div_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             stop,
  input  logic [CNT_W-1:0] div_q,
  output logic [CNT_W-1:0] phase,
  output logic             wrap,
  output logic             tick
);

  localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] phase_r;
  logic             tick_r;
  logic             wrap_s;

  // Last enabled cycle of the current period.
  always_comb begin
    wrap_s = 1'b0;
    if (en && !stop && !clr && (phase_r == div_q - ONE_C)) begin
      wrap_s = 1'b1;
    end else begin
      wrap_s = 1'b0;
    end
  end

  // Phase advance and tick register; phase holds while disabled or stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= {CNT_W{1'b0}};
      tick_r  <= 1'b0;
    end else if (clr) begin
      phase_r <= {CNT_W{1'b0}};
      tick_r  <= 1'b0;
    end else if (en && !stop) begin
      if (wrap_s) begin
        phase_r <= {CNT_W{1'b0}};
      end else begin
        phase_r <= phase_r + ONE_C;
      end
      tick_r <= wrap_s;
    end else begin
      tick_r <= 1'b0;
    end
  end

  assign phase = phase_r;
  assign wrap  = wrap_s;
  assign tick  = tick_r;

endmodule

// File: rtl/pulse_divider.sv
// Programmable tick generator: tick, 50% square wave and tick count, periodic or one-shot.
// Define PULSE_DIV_PHASE_OUT_EN to expose the phase counter on phase_out.
module pulse_divider
  import pulse_div_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned DEF_DIV = DEF_DIV_VAL,
  parameter int unsigned TC_W    = DEF_TC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             oneshot,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             load_pend,
  output logic             div_err,
  output logic             tick,
  output logic             sq_out,
  output logic             done,
  output logic [TC_W-1:0]  tick_cnt
`ifdef PULSE_DIV_PHASE_OUT_EN
  ,
  output logic [CNT_W-1:0] phase_out
`endif
);

  localparam logic [TC_W-1:0] TC_ONE_C = {{(TC_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] div_q_r;
  logic [CNT_W-1:0] shadow_r;
  logic             load_pend_r;
  logic             div_err_r;
  logic             sq_r;
  logic             done_r;
  logic [TC_W-1:0]  tick_cnt_r;
  logic [CNT_W-1:0] phase_s;
  logic             wrap_s;
  logic             tick_s;
  logic             load_ok_s;
  logic             load_bad_s;
  logic             apply_s;

  pulse_div_core #(.CNT_W(CNT_W)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (clr),
    .stop  (done_r),
    .div_q (div_q_r),
    .phase (phase_s),
    .wrap  (wrap_s),
    .tick  (tick_s)
  );

  // Load qualification and the points where the shadow may safely replace div_q.
  always_comb begin
    load_ok_s  = 1'b0;
    load_bad_s = 1'b0;
    apply_s    = 1'b0;
    if (clr) begin
      apply_s = load_pend_r;
    end else begin
      load_ok_s  = div_load && (div_val >= CNT_W'(MIN_DIV));
      load_bad_s = div_load && (div_val <  CNT_W'(MIN_DIV));
      apply_s    = load_pend_r && (wrap_s || (!en && (phase_s == {CNT_W{1'b0}})));
    end
  end

  // Divisor, shadow and load status; a load landing on a wrap waits for the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q_r     <= CNT_W'(DEF_DIV);
      shadow_r    <= {CNT_W{1'b0}};
      load_pend_r <= 1'b0;
      div_err_r   <= 1'b0;
    end else begin
      div_err_r <= load_bad_s;
      if (apply_s) begin
        div_q_r <= shadow_r;
      end else begin
        div_q_r <= div_q_r;
      end
      if (load_ok_s) begin
        shadow_r    <= div_val;
        load_pend_r <= 1'b1;
      end else if (apply_s) begin
        load_pend_r <= 1'b0;
      end else begin
        load_pend_r <= load_pend_r;
      end
    end
  end

  // Square wave, tick count and one-shot latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_r       <= 1'b0;
      done_r     <= 1'b0;
      tick_cnt_r <= {TC_W{1'b0}};
    end else if (clr) begin
      sq_r       <= 1'b0;
      done_r     <= 1'b0;
      tick_cnt_r <= {TC_W{1'b0}};
    end else if (wrap_s) begin
      sq_r       <= ~sq_r;
      tick_cnt_r <= tick_cnt_r + TC_ONE_C;
      done_r     <= done_r | oneshot;
    end else begin
      sq_r       <= sq_r;
      done_r     <= done_r;
      tick_cnt_r <= tick_cnt_r;
    end
  end

  assign load_pend = load_pend_r;
  assign div_err   = div_err_r;
  assign tick      = tick_s;
  assign sq_out    = sq_r;
  assign done      = done_r;
  assign tick_cnt  = tick_cnt_r;
`ifdef PULSE_DIV_PHASE_OUT_EN
  assign phase_out = phase_s;
`endif

endmodule
